// File: rtl/decode_stage_hs.sv
// decode_stage_hs: RV32I decode, register file with write-back bypass,
// load-use stall and a valid/ready ID/EX output register.
module decode_stage_hs #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_pcplus4,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pcplus4,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_regwrite,
    output logic            out_memwrite,
    output logic            out_jump,
    output logic            out_branch,
    output logic            out_alusrc,
    output logic            out_srcasrc,
    output logic            out_jumpreg,
    output logic [1:0]      out_resultsrc,
    output logic [3:0]      out_alucontrol,
    output logic            out_illegal
);

    localparam int RAW = $clog2(NREG);
    localparam logic [5:0] NLIM = 6'(NREG);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASB = 4'd10;

    typedef enum logic [2:0] {
        IMM_Z, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
    } immsrc_e;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrc;
        logic       srcasrc;
        logic       jumpreg;
        logic [1:0] resultsrc;
        logic [3:0] alucontrol;
    } ctl_t;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        ctl_t            c;
        logic            illegal;
    } id_ex_t;

    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign op   = in_instr[6:0];
    assign f3   = in_instr[14:12];
    assign f7b5 = in_instr[30];
    assign rs1  = in_instr[19:15];
    assign rs2  = in_instr[24:20];
    assign rd   = in_instr[11:7];

    logic is_ld, is_st, is_r, is_i, is_br;
    logic is_jal, is_jalr, is_lui, is_auipc;
    logic known;

    assign is_ld    = op == OP_LOAD;
    assign is_st    = op == OP_STORE;
    assign is_r     = op == OP_R;
    assign is_i     = op == OP_I;
    assign is_br    = op == OP_BR;
    assign is_jal   = op == OP_JAL;
    assign is_jalr  = op == OP_JALR;
    assign is_lui   = op == OP_LUI;
    assign is_auipc = op == OP_AUIPC;
    assign known    = |{is_ld, is_st, is_r, is_i, is_br,
                        is_jal, is_jalr, is_lui, is_auipc};

    logic uses_rs1, uses_rs2, uses_rd;

    assign uses_rs2 = is_r | is_st | is_br;
    assign uses_rs1 = uses_rs2 | is_ld | is_i | is_jalr;
    assign uses_rd  = is_r | is_i | is_ld | is_jal
                    | is_jalr | is_lui | is_auipc;

    logic bad_idx, illegal;

    assign bad_idx = (uses_rs1 & ({1'b0, rs1} >= NLIM))
                   | (uses_rs2 & ({1'b0, rs2} >= NLIM))
                   | (uses_rd  & ({1'b0, rd}  >= NLIM));
    assign illegal = !known | bad_idx;

    logic [3:0] aluop;

    always_comb begin
        aluop = ALU_ADD;
        unique case (f3)
            3'b000: aluop = (is_r & f7b5) ? ALU_SUB : ALU_ADD;
            3'b001: aluop = ALU_SLL;
            3'b010: aluop = ALU_SLT;
            3'b011: aluop = ALU_SLTU;
            3'b100: aluop = ALU_XOR;
            3'b101: aluop = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: aluop = ALU_OR;
            3'b111: aluop = ALU_AND;
        endcase
    end

    ctl_t    c;
    immsrc_e immsrc;

    always_comb begin
        c      = '0;
        immsrc = IMM_Z;
        unique case (1'b1)
            is_r: begin
                c.regwrite   = 1'b1;
                c.alucontrol = aluop;
            end
            is_i: begin
                c.regwrite   = 1'b1;
                c.alusrc     = 1'b1;
                c.alucontrol = aluop;
                immsrc       = IMM_I;
            end
            is_ld: begin
                c.regwrite  = 1'b1;
                c.alusrc    = 1'b1;
                c.resultsrc = 2'b01;
                immsrc      = IMM_I;
            end
            is_st: begin
                c.memwrite = 1'b1;
                c.alusrc   = 1'b1;
                immsrc     = IMM_S;
            end
            is_br: begin
                c.branch     = 1'b1;
                c.alucontrol = ALU_SUB;
                immsrc       = IMM_B;
            end
            is_jal: begin
                c.regwrite  = 1'b1;
                c.jump      = 1'b1;
                c.resultsrc = 2'b10;
                immsrc      = IMM_J;
            end
            is_jalr: begin
                c.regwrite  = 1'b1;
                c.jump      = 1'b1;
                c.jumpreg   = 1'b1;
                c.alusrc    = 1'b1;
                c.resultsrc = 2'b10;
                immsrc      = IMM_I;
            end
            is_lui: begin
                c.regwrite   = 1'b1;
                c.alusrc     = 1'b1;
                c.alucontrol = ALU_PASB;
                immsrc       = IMM_U;
            end
            is_auipc: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.srcasrc  = 1'b1;
                immsrc     = IMM_U;
            end
            default: ;
        endcase
    end

    logic [31:0] imm32;
    logic [31:0] ins;

    assign ins = in_instr;

    always_comb begin
        imm32 = '0;
        case (immsrc)
            IMM_I: imm32 = {{20{ins[31]}}, ins[31:20]};
            IMM_S: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: imm32 = {{20{ins[31]}}, ins[7], ins[30:25],
                            ins[11:8], 1'b0};
            IMM_J: imm32 = {{12{ins[31]}}, ins[19:12], ins[20],
                            ins[30:21], 1'b0};
            IMM_U: imm32 = {ins[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    logic [XLEN-1:0] regs [NREG];
    logic            wb_hit;

    assign wb_hit = wb_we & (wb_rd != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_hit && ({1'b0, wb_rd} < NLIM)) begin
            regs[wb_rd[RAW-1:0]] <= wb_data;
        end
    end

    logic [XLEN-1:0] rd1v, rd2v;

    // Same-cycle write-back wins over the stored value
    always_comb begin
        rd1v = '0;
        rd2v = '0;
        if (wb_hit && wb_rd == rs1) rd1v = wb_data;
        else if (rs1 != 5'd0 && {1'b0, rs1} < NLIM)
            rd1v = regs[rs1[RAW-1:0]];
        if (wb_hit && wb_rd == rs2) rd2v = wb_data;
        else if (rs2 != 5'd0 && {1'b0, rs2} < NLIM)
            rd2v = regs[rs2[RAW-1:0]];
    end

    id_ex_t q;
    id_ex_t ent;

    always_comb begin
        ent            = '0;
        ent.rd1        = rd1v;
        ent.rd2        = rd2v;
        ent.imm        = XLEN'($signed(imm32));
        ent.pc         = in_pc;
        ent.pcplus4    = in_pcplus4;
        ent.rs1        = rs1;
        ent.rs2        = rs2;
        ent.rd         = rd;
        ent.funct3     = f3;
        ent.c          = c;
        ent.c.regwrite = c.regwrite & !illegal;
        ent.c.memwrite = c.memwrite & !illegal;
        ent.c.jump     = c.jump & !illegal;
        ent.c.branch   = c.branch & !illegal;
        ent.illegal    = illegal;
    end

    logic ld_out, hz, accept;

    assign ld_out = out_valid & q.c.regwrite
                  & (q.c.resultsrc == 2'b01) & (q.rd != 5'd0);
    assign hz = ld_out & ((q.rd == rs1)
                        | (uses_rs2 & (q.rd == rs2)));
    assign in_ready = !flush & !hz & (!out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= ent;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            // Stalled entry tracks write-backs to its sources
            if (wb_hit && wb_rd == q.rs1) q.rd1 <= wb_data;
            if (wb_hit && wb_rd == q.rs2) q.rd2 <= wb_data;
        end
    end

    assign out_rd1        = q.rd1;
    assign out_rd2        = q.rd2;
    assign out_imm        = q.imm;
    assign out_pc         = q.pc;
    assign out_pcplus4    = q.pcplus4;
    assign out_rs1        = q.rs1;
    assign out_rs2        = q.rs2;
    assign out_rd         = q.rd;
    assign out_funct3     = q.funct3;
    assign out_regwrite   = q.c.regwrite;
    assign out_memwrite   = q.c.memwrite;
    assign out_jump       = q.c.jump;
    assign out_branch     = q.c.branch;
    assign out_alusrc     = q.c.alusrc;
    assign out_srcasrc    = q.c.srcasrc;
    assign out_jumpreg    = q.c.jumpreg;
    assign out_resultsrc  = q.c.resultsrc;
    assign out_alucontrol = q.c.alucontrol;
    assign out_illegal    = q.illegal;

endmodule
